multicycle_decoder: RTL
=======================

MULTICYCLE_DECODER -- requirements
Module: multicycle_decoder

Interface
REQ-001 Parameter OP_W, default 6: opcode width in bits; supported value is 6 only.
REQ-002 Parameter ALU_OP_W, default 3: ALU_op_o width; legal values are >= 3; encodings are zero-extended.
REQ-003 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-004 Clock and reset are fixed: one clock, clk_i; rst_i is synchronous and active-high.
REQ-005 clk_i  in  1  Clock; all state changes on the rising edge.
REQ-006 rst_i  in  1  Synchronous active-high reset.
REQ-007 instr_valid_i  in  1  Fetched instruction word available this cycle.
REQ-008 instr_op_i  in  OP_W  Opcode field; sampled only in FETCH when instr_valid_i=1.
REQ-009 IRWrite_o  out  1  Load the instruction register.
REQ-010 PCWrite_o  out  1  Load PC+4.
REQ-011 RegDst_o  out  1  1 selects rd, 0 selects rt.
REQ-012 ALUSrc_o  out  1  1 selects sign-extended immediate.
REQ-013 ALU_op_o  out  ALU_OP_W  ALU operation class.
REQ-014 Branch_o  out  1  Branch compare/PC-select strobe.
REQ-015 RegWrite_o  out  1  Register-file write enable.
REQ-016 done_o  out  1  One-cycle pulse on instruction retire.
REQ-017 illegal_o  out  1  One-cycle pulse on unsupported opcode.
REQ-018 retired_cnt_o  out  CNT_W  Count of retired (non-illegal) instructions.

Function
REQ-019 States: FETCH, DECODE, EXEC_R, EXEC_I, BRANCH, WB, TRAP; all outputs are Moore, decoded from state and latched opcode.
REQ-020 Control outputs not listed for a state are 0.
REQ-021 FETCH: when instr_valid_i=1, assert IRWrite_o=PCWrite_o=1, latch instr_op_i, go to DECODE; otherwise stay in FETCH with all outputs 0.
REQ-022 DECODE routing by latched opcode: 000000 (R-type) -> EXEC_R; 001000 (addi) -> EXEC_I; 000100 (beq) -> BRANCH; any other opcode -> TRAP.
REQ-023 EXEC_R: RegDst_o=1, ALUSrc_o=0, ALU_op_o=010; next state is WB.
REQ-024 EXEC_I: RegDst_o=0, ALUSrc_o=1, ALU_op_o=000 for addi (110 for ori); next state is WB.
REQ-025 WB: RegWrite_o=1; RegDst_o, ALUSrc_o and ALU_op_o hold the EXEC values; done_o=1; next state is FETCH.
REQ-026 BRANCH: Branch_o=1, ALUSrc_o=0, ALU_op_o=001 for beq (011 for bne), done_o=1; next state is FETCH.
REQ-027 TRAP: illegal_o=1 and all other control outputs 0, including RegWrite_o, Branch_o and done_o; counter unchanged; next state is FETCH.
REQ-028 Latency from the accepting FETCH cycle: R/I-type retire 3 cycles later (4 states); branch 2 cycles later; illegal 2 cycles later.
REQ-029 instr_valid_i and instr_op_i are ignored outside FETCH; a new instruction can be accepted in the cycle immediately after done_o or illegal_o.
REQ-030 retired_cnt_o increments by 1 in the cycle after done_o=1 and wraps from 2^CNT_W-1 to 0 without a flag.
REQ-031 done_o and illegal_o are never asserted in the same cycle.

Reset
REQ-032 rst_i=1 at a clock edge forces state FETCH, clears the latched opcode to 0, clears retired_cnt_o to 0, and drives all outputs 0 in the following cycle.
REQ-033 Reset takes priority in any state; an in-flight instruction is abandoned with no RegWrite_o, done_o or counter update.
REQ-034 instr_valid_i is ignored in any cycle where rst_i=1.

Configuration
REQ-035 Macro DECODER_EXT_OPS_EN defined: opcode 000101 (bne) routes to BRANCH with ALU_op_o=011, and opcode 001101 (ori) routes to EXEC_I with ALU_op_o=110.
REQ-036 Macro DECODER_EXT_OPS_EN undefined: opcodes 000101 and 001101 route to TRAP like any other unsupported opcode.

Verification
REQ-037 Reset, then R-type 000000 with valid -> IRWrite/PCWrite at cycle 0, RegDst=1/ALU_op=010 at cycle 2, RegWrite=1 and done=1 at cycle 3, count=1.
REQ-038 addi 001000 followed by beq 000100 issued back-to-back -> ALUSrc=1/ALU_op=000, then Branch=1/ALU_op=001; both done pulses observed; count=2.
REQ-039 Opcode 000010 -> illegal_o pulses in TRAP, RegWrite never asserts, count unchanged; repeat with 000101 and the macro undefined -> same result.
REQ-040 Macro defined: bne 000101 -> Branch=1/ALU_op=011; ori 001101 -> ALUSrc=1/ALU_op=110 with RegWrite at WB.
REQ-041 rst_i asserted during EXEC_R -> next cycle in FETCH, outputs 0, no done pulse, count=0.
REQ-042 CNT_W=4, retire 17 instructions -> retired_cnt_o=1 after the wrap.

Source files
------------

// File: rtl/multicycle_decoder.sv
// Multicycle control decoder: FETCH/DECODE/EXEC/WB/BRANCH/TRAP sequencer
// with Moore controls and a wrapping retired-instruction counter.
//
// Ports:
//   clk_i, rst_i (sync, active-high), instr_valid_i, instr_op_i
//   IRWrite_o, PCWrite_o, RegDst_o, ALUSrc_o, ALU_op_o, Branch_o,
//   RegWrite_o, done_o, illegal_o, retired_cnt_o
// Optional build macro: DECODER_EXT_OPS_EN adds bne (000101) and
// ori (001101); without it those opcodes trap.
`timescale 1ns/1ps
module multicycle_decoder #(
   parameter int OP_W     = 6,
   parameter int ALU_OP_W = 3,
   parameter int CNT_W    = 16
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                instr_valid_i,
   input  logic [OP_W-1:0]     instr_op_i,
   output logic                IRWrite_o,
   output logic                PCWrite_o,
   output logic                RegDst_o,
   output logic                ALUSrc_o,
   output logic [ALU_OP_W-1:0] ALU_op_o,
   output logic                Branch_o,
   output logic                RegWrite_o,
   output logic                done_o,
   output logic                illegal_o,
   output logic [CNT_W-1:0]    retired_cnt_o
);

   typedef enum logic [2:0] {
      FETCH, DECODE, EXEC_R, EXEC_I, BRANCH, WB, TRAP
   } state_t;

   localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
   localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
   localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
   localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
   localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b001101);

   localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(3'b000);
   localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(3'b001);
   localparam logic [ALU_OP_W-1:0] ALU_FN  = ALU_OP_W'(3'b010);
   localparam logic [ALU_OP_W-1:0] ALU_NE  = ALU_OP_W'(3'b011);
   localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(3'b110);

   state_t            state_q, state_d;
   logic [OP_W-1:0]   op_q;
   logic [CNT_W-1:0]  cnt_q;

   logic is_r, is_i, is_br, is_bne, is_ori;

   assign is_r = (op_q == OP_RTYPE);
`ifdef DECODER_EXT_OPS_EN
   assign is_bne = (op_q == OP_BNE);
   assign is_ori = (op_q == OP_ORI);
`else
   assign is_bne = 1'b0;
   assign is_ori = 1'b0;
`endif
   assign is_i  = (op_q == OP_ADDI) | is_ori;
   assign is_br = (op_q == OP_BEQ) | is_bne;

   assign retired_cnt_o = cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= FETCH;
         op_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (IRWrite_o)
            op_q <= instr_op_i;
         if (done_o)
            cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      state_d    = state_q;
      IRWrite_o  = 1'b0;
      PCWrite_o  = 1'b0;
      RegDst_o   = 1'b0;
      ALUSrc_o   = 1'b0;
      ALU_op_o   = '0;
      Branch_o   = 1'b0;
      RegWrite_o = 1'b0;
      done_o     = 1'b0;
      illegal_o  = 1'b0;
      unique case (state_q)
         FETCH: begin
            // A word offered while reset is asserted is never taken.
            if (instr_valid_i && !rst_i) begin
               IRWrite_o = 1'b1;
               PCWrite_o = 1'b1;
               state_d   = DECODE;
            end
         end
         DECODE: begin
            unique case (1'b1)
               is_r:    state_d = EXEC_R;
               is_i:    state_d = EXEC_I;
               is_br:   state_d = BRANCH;
               default: state_d = TRAP;
            endcase
         end
         EXEC_R: begin
            RegDst_o = 1'b1;
            ALU_op_o = ALU_FN;
            state_d  = WB;
         end
         EXEC_I: begin
            ALUSrc_o = 1'b1;
            ALU_op_o = is_ori ? ALU_OR : ALU_ADD;
            state_d  = WB;
         end
         WB: begin
            // Datapath selects stay stable through the write.
            RegWrite_o = 1'b1;
            done_o     = 1'b1;
            if (is_r) begin
               RegDst_o = 1'b1;
               ALU_op_o = ALU_FN;
            end else begin
               ALUSrc_o = 1'b1;
               ALU_op_o = is_ori ? ALU_OR : ALU_ADD;
            end
            state_d = FETCH;
         end
         BRANCH: begin
            Branch_o = 1'b1;
            ALU_op_o = is_bne ? ALU_NE : ALU_SUB;
            done_o   = 1'b1;
            state_d  = FETCH;
         end
         TRAP: begin
            illegal_o = 1'b1;
            state_d   = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end

endmodule
